// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared MIPS core types and encodings (control bundle, ALU ops)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] reg_dst;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W = 12;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOR  = 4'h5;
   localparam logic [3:0] ALU_SLT  = 4'h6;
   localparam logic [3:0] ALU_SLTU = 4'h7;
   localparam logic [3:0] ALU_SLL  = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_SRA  = 4'hA;
   localparam logic [3:0] ALU_LUI  = 4'hB;

   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   localparam logic [4:0] ZERO_REG    = 5'd0;
   localparam ctrl_t      CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/wb_bypass.sv
// ============================================================================
// wb_bypass : selects the write-back value when it targets the given register
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wb_bypass
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   output logic [DATA_W-1:0] data_o
);

   logic w_hit;

   // $zero is hard-wired, so a write-back aimed at it must never leak through
   assign w_hit  = wb_we_i && (wb_addr_i != ADDR_W'(ZERO_REG)) && (wb_addr_i == addr_i);
   assign data_o = w_hit ? wb_data_i : data_i;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// ============================================================================
// id_ex_stage_reg : ID/EX pipeline register with stall, flush, WB bypass and
//                   saturating debug counters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module id_ex_stage_reg
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic [4:0]        id_shamt,
   input  logic [11:0]       id_ctrl,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [ADDR_W-1:0] ex_rs,
   output logic [ADDR_W-1:0] ex_rt,
   output logic [ADDR_W-1:0] ex_rd,
   output logic [4:0]        ex_shamt,
   output logic [11:0]       ex_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic              ex_valid_q,   ex_valid_d;
   logic [DATA_W-1:0] ex_pc4_q,     ex_pc4_d;
   logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
   logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
   logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
   logic [ADDR_W-1:0] ex_rs_q,      ex_rs_d;
   logic [ADDR_W-1:0] ex_rt_q,      ex_rt_d;
   logic [ADDR_W-1:0] ex_rd_q,      ex_rd_d;
   logic [4:0]        ex_shamt_q,   ex_shamt_d;
   ctrl_t             ex_ctrl_q,    ex_ctrl_d;
   logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

   logic [DATA_W-1:0] w_ld_rs_data, w_ld_rt_data;
   logic [DATA_W-1:0] w_hold_rs_data, w_hold_rt_data;
   logic              w_bubble;

   wb_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_ld_rs (
      .addr_i(id_rs), .data_i(id_rs_data), .wb_we_i(wb_we),
      .wb_addr_i(wb_addr), .wb_data_i(wb_data), .data_o(w_ld_rs_data)
   );

   wb_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_ld_rt (
      .addr_i(id_rt), .data_i(id_rt_data), .wb_we_i(wb_we),
      .wb_addr_i(wb_addr), .wb_data_i(wb_data), .data_o(w_ld_rt_data)
   );

   wb_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_hold_rs (
      .addr_i(ex_rs_q), .data_i(ex_rs_data_q), .wb_we_i(wb_we),
      .wb_addr_i(wb_addr), .wb_data_i(wb_data), .data_o(w_hold_rs_data)
   );

   wb_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_hold_rt (
      .addr_i(ex_rt_q), .data_i(ex_rt_data_q), .wb_we_i(wb_we),
      .wb_addr_i(wb_addr), .wb_data_i(wb_data), .data_o(w_hold_rt_data)
   );

   // An invalid decode slot on a load edge is indistinguishable from a flush
   assign w_bubble = flush || (!stall && !id_valid);

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_pc4_d     = ex_pc4_q;
      ex_rs_data_d = ex_rs_data_q;
      ex_rt_data_d = ex_rt_data_q;
      ex_imm_d     = ex_imm_q;
      ex_rs_d      = ex_rs_q;
      ex_rt_d      = ex_rt_q;
      ex_rd_d      = ex_rd_q;
      ex_shamt_d   = ex_shamt_q;
      ex_ctrl_d    = ex_ctrl_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;

      if (w_bubble) begin
         ex_valid_d   = 1'b0;
         ex_pc4_d     = '0;
         ex_rs_data_d = '0;
         ex_rt_data_d = '0;
         ex_imm_d     = '0;
         ex_rs_d      = '0;
         ex_rt_d      = '0;
         ex_rd_d      = '0;
         ex_shamt_d   = '0;
         ex_ctrl_d    = CTRL_BUBBLE;
      end else if (stall) begin
         if (ex_valid_q) begin
            ex_rs_data_d = w_hold_rs_data;
            ex_rt_data_d = w_hold_rt_data;
         end
      end else begin
         ex_valid_d   = 1'b1;
         ex_pc4_d     = id_pc4;
         ex_rs_data_d = w_ld_rs_data;
         ex_rt_data_d = w_ld_rt_data;
         ex_imm_d     = id_imm;
         ex_rs_d      = id_rs;
         ex_rt_d      = id_rt;
         ex_rd_d      = id_rd;
         ex_shamt_d   = id_shamt;
         ex_ctrl_d    = ctrl_t'(id_ctrl);
      end

      if (flush && (flush_cnt_q != c_CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
      if (!flush && stall && (stall_cnt_q != c_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         ex_pc4_q     <= '0;
         ex_rs_data_q <= '0;
         ex_rt_data_q <= '0;
         ex_imm_q     <= '0;
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_rd_q      <= '0;
         ex_shamt_q   <= '0;
         ex_ctrl_q    <= CTRL_BUBBLE;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_pc4_q     <= ex_pc4_d;
         ex_rs_data_q <= ex_rs_data_d;
         ex_rt_data_q <= ex_rt_data_d;
         ex_imm_q     <= ex_imm_d;
         ex_rs_q      <= ex_rs_d;
         ex_rt_q      <= ex_rt_d;
         ex_rd_q      <= ex_rd_d;
         ex_shamt_q   <= ex_shamt_d;
         ex_ctrl_q    <= ex_ctrl_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_pc4     = ex_pc4_q;
   assign ex_rs_data = ex_rs_data_q;
   assign ex_rt_data = ex_rt_data_q;
   assign ex_imm     = ex_imm_q;
   assign ex_rs      = ex_rs_q;
   assign ex_rt      = ex_rt_q;
   assign ex_rd      = ex_rd_q;
   assign ex_shamt   = ex_shamt_q;
   assign ex_ctrl    = ex_ctrl_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

`default_nettype wire

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between instruction decode and execute in the MIPS core.
- Captures the decode outputs: the 32-bit extended immediate, the register-file read data, register addresses, shamt, PC+4 and the control bundle.
- Presents them to the ALU/forwarding logic one cycle later.
- Supports hazard-unit stall (hold) and flush (bubble insertion).
- Provides a write-back write-through bypass so held operands never go stale.
- Keeps saturating stall/flush counters for debug.

Parameters:
DATA_W, 32, datapath width (PC, operands, immediate)
ADDR_W, 5, register address width
CNT_W, 16, width of the stall/flush counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
stall  in  1  hazard unit: hold current contents
flush  in  1  hazard/branch unit: replace contents with bubble
id_pc4  in  DATA_W  PC+4 of the decoded instruction
id_rs_data  in  DATA_W  register-file read port A
id_rt_data  in  DATA_W  register-file read port B
id_imm  in  DATA_W  extended immediate from the sign/zero-extend unit
id_rs, id_rt, id_rd  in  ADDR_W each  register addresses
id_shamt  in  5  shift amount
id_ctrl  in  12  control bundle {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst[1:0], alu_op[3:0]}
wb_we  in  1  write-back stage writes the register file this cycle
wb_addr  in  ADDR_W  write-back destination
wb_data  in  DATA_W  write-back value
ex_valid  out  1  EX slot holds a real instruction
ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered copies
ex_rs, ex_rt, ex_rd  out  ADDR_W  registered copies
ex_shamt  out  5  registered copy
ex_ctrl  out  12  registered control bundle
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of flush cycles

Behaviour:
- Reset (rst_n low, asynchronous): every output goes to 0 immediately and stays 0 while rst_n is low.
- Reset mid-stall or mid-flush: the same, the register is simply cleared. The first edge after release performs a normal update.
- Latency: one clock. Outputs change only on the rising edge of clk.
- Priority per edge is flush > stall > load.
- Flush:
  - ex_valid <= 0; ex_ctrl <= 0 (which forces reg_write, mem_read, mem_write, branch to 0); all data and address outputs <= 0.
  - flush_cnt increments. flush wins when stall is also high.
- Stall (flush = 0):
  - All outputs hold, except the bypass update below.
  - stall_cnt increments.
- Load (stall = 0, flush = 0):
  - If id_valid = 1: capture all id_* fields and set ex_valid <= 1.
  - If id_valid = 0: load a bubble, identical to flush, but flush_cnt is not incremented.
- Write-through bypass on load:
  - If wb_we = 1, wb_addr != 0 and wb_addr == id_rs, capture wb_data into ex_rs_data instead of id_rs_data.
  - The same rule applies independently for rt (id_rt, ex_rt_data).
  - rs and rt may both match the same wb_addr; both are then replaced.
- Bypass during stall:
  - If wb_we = 1, wb_addr != 0 and wb_addr == ex_rs, update ex_rs_data <= wb_data. Same for rt.
  - This applies only while ex_valid = 1.
- Register 0: never bypassed. Reads of address 0 pass through unchanged.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones with no wrap.
  - Both counters clear only on reset.
- ex_imm is stored verbatim. No re-extension is done here; sign versus zero extension is already decided upstream.

Decomposition:
- Shared package cpu_pkg:
  - typedef of the 12-bit control bundle struct with its field order.
  - alu_op encodings and reg_dst encodings.
  - constant ZERO_REG = 0.
  - constant CTRL_BUBBLE = 0.
- Sub-module wb_bypass (combinational):
  - Inputs: addr, data, wb_we, wb_addr, wb_data. Output: the selected data, with the zero-register guard.
  - Instantiated four times: rs/rt on the load path and rs/rt on the hold path.

Test Plan:
- Reset: drive random inputs, pulse rst_n low between clock edges -> all outputs 0 immediately, counters 0.
- Normal load: id_valid=1, id_imm=32'hFFFF8000, id_rs=5, id_rs_data=32'h11, id_ctrl=12'hA53 -> next edge ex_imm=32'hFFFF8000, ex_rs_data=32'h11, ex_ctrl=12'hA53, ex_valid=1.
- Load bypass: id_rs=id_rt=7, wb_we=1, wb_addr=7, wb_data=32'hDEAD -> ex_rs_data=ex_rt_data=32'hDEAD. Repeat with all addresses 0 and wb_addr=0 -> id data passes, not wb_data.
- Stall: hold for 3 cycles while WB writes ex_rt with 32'h1234 in cycle 2 -> ex_rt_data=32'h1234 from cycle 3, all other outputs unchanged, stall_cnt=3.
- Flush with stall: stall=flush=1 for one edge -> ex_valid=0, ex_ctrl=0, flush_cnt=1, stall_cnt unchanged. id_valid=0 load -> bubble, flush_cnt unchanged.
- Saturation: with CNT_W=4, hold stall for 20 cycles -> stall_cnt=4'hF, no wrap.
